ifetch: RTL and testbench
=========================

Name: ifetch

Overview:
- Instruction-fetch stage directly upstream of idecode.
- Owns the program counter and issues word addresses to the synchronous instruction memory.
- Captures the returned instruction words into a small in-order queue and presents them to the decoder with a valid/ready handshake.
- Supports redirect (jump/branch) with flush. Replaces the free-running pc block plus the pc>>2 address glue.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- DEPTH, 4, instruction-queue entries; power of two, minimum 2; 4 gives one instruction per cycle.

Ports:
- clk  in  1  clock, all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_enable  in  1  1 = issue fetches; 0 = stop issuing and let the queue drain.
- mem_read_enable  out  1  fetch issued this cycle.
- mem_address  out  32  word address to memory = pc >> 2.
- mem_data_in  in  32  instruction word from memory, valid the cycle after issue.
- redirect_valid  in  1  jump/branch taken; single-cycle pulse.
- redirect_pc  in  32  new byte PC.
- instr_out  out  32  instruction at queue head.
- instr_pc  out  32  byte PC of instr_out.
- instr_valid  out  1  queue non-empty.
- instr_ready  in  1  decoder accepts head.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; queue count=0; inflight=0; state=IDLE.
  - Queue storage cleared, so instr_out=0, instr_pc=0, instr_valid=0.
  - mem_read_enable=0 and mem_address=RESET_PC>>2 while in reset.
- FSM:
  - IDLE -> RUN when fetch_enable=1.
  - RUN -> IDLE when fetch_enable=0.
  - Issue only in RUN.
- Issue condition (combinational):
  - issue = RUN & !redirect_valid & (count + inflight < DEPTH).
  - The credit check does not use instr_ready (no ready-to-address comb path).
- On issue:
  - mem_read_enable=1, mem_address=pc[31:2].
  - Next pc=pc+4 (32-bit wrap; 0xFFFF_FFFC+4=0).
  - inflight<=1 and req_pc<=pc; otherwise inflight<=0.
- Capture:
  - In the cycle after issue, if inflight=1 and not squashed, push {req_pc, mem_data_in} at the queue tail.
  - Issue edge to instr_valid high: 2 edges.
- Pop:
  - instr_valid & instr_ready at an edge removes the head.
  - Push and pop may coincide; count is unchanged and order is preserved.
  - Overflow is impossible by the credit rule. An overflow or underflow is a design error and is flagged by assertion.
- Redirect (redirect_valid=1 at an edge), regardless of state:
  - Queue flushed (count=0); any pop that edge is ignored.
  - The inflight word is squashed: the capture cycle after a redirect discards mem_data_in.
  - pc<=redirect_pc with bits [1:0] forced to 0.
  - No issue that cycle; first issue of the new PC is the next RUN cycle.
  - instr_valid=0 the cycle after redirect.
- fetch_enable=0: issuing stops immediately. An inflight word still lands, and the queue drains normally.
- Reset mid-operation: all state clears asynchronously. Inflight data after reset release is not captured (inflight=0).
- Steady state (DEPTH=4, instr_ready=1): one issue and one pop per cycle.

Decomposition:
- ifetch_pkg holds:
  - fetch state enum {IDLE, RUN};
  - INSTR_WIDTH=32;
  - default RESET_PC;
  - NOP constant 32'h0000_0013 (addi x0,x0,0), for benches.
- Sub-module fetch_queue: synchronous FIFO storing {pc, instr}.
  - Synchronous flush, count output, async active-low reset clearing storage.
- ifetch holds the pc, FSM, inflight tracking and credit logic.

Test Plan:
- Reset, fetch_enable=1, instr_ready=1, memory words 0..7 = 0x00100093+k.
  -> First mem_read_enable at edge 0 with address 0.
  -> instr_valid from edge 2.
  -> instr_pc 0,4,8,... one per cycle, instr_out matching the memory word.
- instr_ready=0 from start.
  -> Exactly 4 issues, then mem_read_enable=0, queue holds pcs 0,4,8,12.
  -> Raising ready yields them in order, then fetching resumes at 16 with no gap or duplicate.
- Redirect_valid with redirect_pc=0x40 while queue holds 2 entries and one word is inflight.
  -> instr_valid=0 next cycle, inflight word discarded.
  -> Next issued address 0x10, first instr_pc=0x40.
- redirect_pc=0x43.
  -> Fetch from mem_address 0x10, instr_pc=0x40.
- pc=0xFFFF_FFFC via redirect.
  -> Addresses 0x3FFF_FFFF then 0x0000_0000, instr_pc wraps to 0.
- Queue full, drop rst_n mid-cycle.
  -> instr_valid=0, instr_out=0 before the next edge.
  -> After release, first issue at RESET_PC>>2.
  -> No stale word enqueued.

Source files
------------

// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the instruction-fetch stage
package ifetch_pkg;

  localparam int          INSTR_WIDTH      = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]            pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - memory, redirect and decoder-side signals of the fetch stage
interface ifetch_if;
  import ifetch_pkg::*;

  logic                   fetch_enable;
  logic                   mem_read_enable;
  logic [31:0]            mem_address;
  logic [INSTR_WIDTH-1:0] mem_data_in;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;
  logic [INSTR_WIDTH-1:0] instr_out;
  logic [31:0]            instr_pc;
  logic                   instr_valid;
  logic                   instr_ready;

  modport master (
    input  fetch_enable, mem_data_in, redirect_valid, redirect_pc, instr_ready,
    output mem_read_enable, mem_address, instr_out, instr_pc, instr_valid
  );

  modport slave (
    output fetch_enable, mem_data_in, redirect_valid, redirect_pc, instr_ready,
    input  mem_read_enable, mem_address, instr_out, instr_pc, instr_valid
  );

endinterface

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - in-order {pc, instr} FIFO with synchronous flush
module fetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  // Flush dominates: an entry arriving or leaving on a flush edge is dropped.
  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~flush_i & (count_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assert property (@(posedge clk) disable iff (!rst_n)
    !(do_push && !do_pop && count_q == CW'(DEPTH)));
  assert property (@(posedge clk) disable iff (!rst_n)
    !(pop_i && !flush_i && count_q == '0));

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - pc, fetch FSM, inflight tracking and queue credit for the fetch stage
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 4
) (
  input logic     clk,
  input logic     rst_n,
  ifetch_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_RUN  = RUN;

  logic [0:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] count;
  logic [CW:0]   used;
  logic          issue, push, pop;
  fetch_entry_t  head, push_data;

  // Credit counts the inflight word so a full queue can never be overrun.
  assign used  = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign issue = (state_q == S_RUN) & bus.fetch_enable & ~bus.redirect_valid
               & (used < (CW+1)'(DEPTH));

  always_comb begin
    state_d    = bus.fetch_enable ? S_RUN : S_IDLE;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    if (bus.redirect_valid) pc_d = {bus.redirect_pc[31:2], 2'b00};
    else if (issue)         pc_d = pc_q + 32'd4;
    if (issue) req_pc_d = pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  assign push      = inflight_q & ~bus.redirect_valid;
  assign pop       = bus.instr_valid & bus.instr_ready;
  assign push_data = '{pc: req_pc_q, instr: bus.mem_data_in};

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (bus.redirect_valid),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count)
  );

  assign bus.mem_read_enable = issue;
  assign bus.mem_address     = {2'b00, pc_q[31:2]};
  assign bus.instr_out       = head.instr;
  assign bus.instr_pc        = head.pc;
  assign bus.instr_valid     = (count != '0);

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - randomized self-checking bench for ifetch against a queue-based model
module tb_ifetch;
  import ifetch_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ifetch_if bus_if ();

  ifetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] mq[$];
  logic [31:0] m_pc, m_inf_pc;
  bit          m_inf, m_run;
  bit          mem_pend;
  logic [31:0] mem_addr;
  int          issue_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] waddr);
    return 32'h0010_0093 + waddr;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc     = RPC;
    m_inf    = 1'b0;
    m_inf_pc = '0;
    m_run    = 1'b0;
    mem_pend = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_valid", {31'b0, bus_if.instr_valid}, 32'd0);
    check_eq("rst_instr", bus_if.instr_out, 32'd0);
    check_eq("rst_pc",    bus_if.instr_pc, 32'd0);
    check_eq("rst_rden",  {31'b0, bus_if.mem_read_enable}, 32'd0);
    check_eq("rst_addr",  bus_if.mem_address, RPC >> 2);
  endtask

  // One clock cycle: drive at negedge, compare, advance model, feed memory after the edge.
  task automatic step(input bit fe, input bit rdy, input bit rv, input logic [31:0] rp);
    bit          exp_issue;
    logic [63:0] e;
    bus_if.fetch_enable   = fe;
    bus_if.instr_ready    = rdy;
    bus_if.redirect_valid = rv;
    bus_if.redirect_pc    = rp;
    #1;
    exp_issue = m_run && fe && !rv && (mq.size() + int'(m_inf) < DEPTH);
    check_eq("rd_en", {31'b0, bus_if.mem_read_enable}, {31'b0, exp_issue});
    check_eq("addr",  bus_if.mem_address, m_pc >> 2);
    check_eq("valid", {31'b0, bus_if.instr_valid}, {31'b0, mq.size() != 0});
    if (mq.size() != 0) begin
      e = mq[0];
      check_eq("instr_pc",  bus_if.instr_pc,  e[63:32]);
      check_eq("instr_out", bus_if.instr_out, e[31:0]);
    end
    if (bus_if.mem_read_enable) issue_cnt++;
    mem_pend = bus_if.mem_read_enable;
    mem_addr = bus_if.mem_address;

    if (rv) mq.delete();
    else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (m_inf) mq.push_back({m_inf_pc, mem_word(m_inf_pc >> 2)});
    end
    m_inf    = exp_issue;
    m_inf_pc = m_pc;
    if (rv)             m_pc = {rp[31:2], 2'b00};
    else if (exp_issue) m_pc = m_pc + 32'd4;
    m_run = fe;

    @(posedge clk);
    #1;
    bus_if.mem_data_in = mem_pend ? mem_word(mem_addr) : $urandom;
    @(negedge clk);
  endtask

  logic [31:0] rp_pick;

  initial begin
    rst_n                 = 1'b0;
    bus_if.fetch_enable   = 1'b0;
    bus_if.instr_ready    = 1'b0;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = '0;
    bus_if.mem_data_in    = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    // Decoder stalled from the start: queue fills to exactly DEPTH entries.
    issue_cnt = 0;
    repeat (12) step(1'b1, 1'b0, 1'b0, '0);
    check_eq("stall_issues", issue_cnt, DEPTH);
    repeat (30) step(1'b1, 1'b1, 1'b0, '0);

    // Redirects with words queued and inflight, unaligned target, and pc wrap.
    repeat (2) step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0040);
    repeat (6) step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0043);
    repeat (6) step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    repeat (8) step(1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    repeat (6) step(1'b0, 1'b1, 1'b0, '0);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(3, 0))
        0:       rp_pick = 32'h0000_0043;
        1:       rp_pick = 32'hFFFF_FFF8;
        default: rp_pick = $urandom;
      endcase
      step(($urandom % 8) != 0, ($urandom % 3) != 0, ($urandom % 16) == 0, rp_pick);
    end

    // Fill the queue, then reset asynchronously between edges.
    repeat (10) step(1'b1, 1'b0, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) step(1'b1, 1'b1, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
